// File: rtl/wb_scoreboard_pkg.sv
// rtl/wb_scoreboard_pkg.sv - shared widths and writeback request type for the writeback scoreboard
package wb_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // One writeback request as seen by the arbiter.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '0;

endpackage

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-way ALU/load writeback arbiter with registered register-file drive (WB_STARVE_GUARD_EN adds load starve guard)
module wb_arb2
  import wb_scoreboard_pkg::*;
`ifdef WB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 3
)
`endif
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  wb_req_t               alu_req,
  input  wb_req_t               ld_req,
  output logic                  ld_ready,
  output logic                  alu_hold,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]       rf_write_data
);

  logic    force_ld;
  wb_req_t grant;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Once the load has lost STARVE_LIMIT times in a row it takes the port.
  assign force_ld = ld_req.valid && (starve_cnt == SW'(STARVE_LIMIT));

  // Count consecutive cycles a waiting load write was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (ld_req.valid && ld_ready) begin
      starve_cnt <= '0;
    end else if (ld_req.valid) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_ld = 1'b0;
`endif

  // Pick the winner: forced load, else ALU, else load.
  always_comb begin
    grant    = WB_REQ_IDLE;
    ld_ready = force_ld || !alu_req.valid;
    alu_hold = force_ld;
    if (force_ld) begin
      grant = ld_req;
    end else if (alu_req.valid) begin
      grant = alu_req;
    end else if (ld_req.valid) begin
      grant = ld_req;
    end
  end

  // Register the winner onto the register-file write port; x0 writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= grant.valid && (grant.rd != '0);
      rf_write_reg    <= grant.rd;
      rf_write_data   <= grant.data;
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - long-latency write scoreboard with ALU/load writeback arbitration (optional WB_STARVE_GUARD_EN)
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_long,
  output logic                  issue_stall,
  input  logic                  alu_wb_valid,
  input  logic [REG_ADDR_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]       alu_wb_data,
  output logic                  alu_hold,
  input  logic                  ld_wb_valid,
  input  logic [REG_ADDR_W-1:0] ld_wb_rd,
  input  logic [XLEN-1:0]       ld_wb_data,
  output logic                  ld_wb_ready,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_reg,
  output logic [XLEN-1:0]       rf_write_data
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Reject parameter values outside the supported range at elaboration.
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || STARVE_LIMIT < 1) begin : g_param_check
    $error("wb_scoreboard: parameter out of range");
  end

  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    count;
  logic                count_full;
  logic                do_set;
  logic                do_clr;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  wb_req_t             alu_req;
  wb_req_t             ld_req;

  assign alu_req    = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
  assign ld_req     = '{valid: ld_wb_valid,  rd: ld_wb_rd,  data: ld_wb_data};
  assign count_full = (count == CNT_W'(MAX_OUTSTANDING));

  // Hazard check uses the pending state before this cycle's clear.
  always_comb begin
    issue_stall = issue_valid && (pending[issue_rs1] || pending[issue_rs2] ||
                                  pending[issue_rd]  || (issue_long && count_full));
  end

  // A set and a clear never target the same register: a pending rd stalls issue.
  assign do_set   = issue_valid && issue_long && !issue_stall && (issue_rd != '0);
  assign do_clr   = ld_wb_valid && ld_wb_ready && pending[ld_wb_rd];
  assign set_mask = NUM_REGS'(do_set) << issue_rd;
  assign clr_mask = NUM_REGS'(do_clr) << ld_wb_rd;

  // Track outstanding long writes; x0 is never marked pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
      case ({do_set, do_clr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  wb_arb2
`ifdef WB_STARVE_GUARD_EN
    #(.STARVE_LIMIT(STARVE_LIMIT))
`endif
  u_arb (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_req         (alu_req),
    .ld_req          (ld_req),
    .ld_ready        (ld_wb_ready),
    .alu_hold        (alu_hold),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data)
  );

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb/tb_wb_scoreboard.sv - self-checking bench for wb_scoreboard (vector table, corner sequences, random vs model)
module tb_wb_scoreboard;

  localparam int MAX_OUT = 4;
  localparam int SLIMIT  = 3;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_long;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        alu_hold;
  logic        ld_wb_valid;
  logic [4:0]  ld_wb_rd;
  logic [31:0] ld_wb_data;
  logic        ld_wb_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  wb_scoreboard #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(SLIMIT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_rd        (issue_rd),
    .issue_long      (issue_long),
    .issue_stall     (issue_stall),
    .alu_wb_valid    (alu_wb_valid),
    .alu_wb_rd       (alu_wb_rd),
    .alu_wb_data     (alu_wb_data),
    .alu_hold        (alu_hold),
    .ld_wb_valid     (ld_wb_valid),
    .ld_wb_rd        (ld_wb_rd),
    .ld_wb_data      (ld_wb_data),
    .ld_wb_ready     (ld_wb_ready),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: set of outstanding registers, their number, starve streak.
  bit mp [32];
  int mc;
  int m_starve;

  typedef struct {
    bit iv; int rs1; int rs2; int rd; bit lng;
    bit av; int ard; bit lv; int lrd;
    bit s; bit r; int cnt; bit wen; int wreg;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mp[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mp[i] = 0;
    mc = 0;
    m_starve = 0;
  endtask

  task automatic drive(input bit iv, input int rs1, input int rs2, input int rd, input bit lng,
                       input bit av, input int ard, input bit lv, input int lrd);
    issue_valid  = iv;
    issue_rs1    = 5'(rs1);
    issue_rs2    = 5'(rs2);
    issue_rd     = 5'(rd);
    issue_long   = lng;
    alu_wb_valid = av;
    alu_wb_rd    = 5'(ard);
    alu_wb_data  = $urandom;
    ld_wb_valid  = lv;
    ld_wb_rd     = 5'(lrd);
    ld_wb_data   = $urandom;
  endtask

  // Called mid-cycle with inputs settled; checks combinational outputs, steps the model
  // across the edge and then checks registered outputs and scoreboard state.
  task automatic do_cycle(input string tag);
    bit force_ld, e_stall, e_ready, w_v;
    int w_rd;
    logic [31:0] w_data;
    force_ld = 0;
`ifdef WB_STARVE_GUARD_EN
    force_ld = ld_wb_valid && (m_starve == SLIMIT);
`endif
    e_stall = issue_valid && (mp[issue_rs1] || mp[issue_rs2] || mp[issue_rd] ||
                              (issue_long && mc == MAX_OUT));
    e_ready = force_ld || !alu_wb_valid;
    chk({tag, " stall"}, 32'(issue_stall), 32'(e_stall));
    chk({tag, " ready"}, 32'(ld_wb_ready), 32'(e_ready));
    chk({tag, " hold"},  32'(alu_hold),    32'(force_ld));
    w_v = 0; w_rd = 0; w_data = 0;
    if (ld_wb_valid && e_ready) begin
      w_v = 1; w_rd = int'(ld_wb_rd); w_data = ld_wb_data;
    end else if (alu_wb_valid) begin
      w_v = 1; w_rd = int'(alu_wb_rd); w_data = alu_wb_data;
    end
    @(posedge clk);
    if (ld_wb_valid && e_ready && mp[ld_wb_rd]) begin
      mp[ld_wb_rd] = 0;
      mc--;
    end
    if (issue_valid && issue_long && !e_stall && issue_rd != 0) begin
      mp[issue_rd] = 1;
      mc++;
    end
    if (ld_wb_valid && e_ready) m_starve = 0;
    else if (ld_wb_valid) m_starve++;
    #1;
    chk({tag, " wen"}, 32'(rf_write_enable), 32'(w_v && w_rd != 0));
    if (w_v && w_rd != 0) begin
      chk({tag, " wreg"},  32'(rf_write_reg), 32'(w_rd));
      chk({tag, " wdata"}, rf_write_data, w_data);
    end
    chk({tag, " pending"}, dut.pending, m_pend());
    chk({tag, " count"},   32'(dut.count), 32'(mc));
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 5, 1,  0, 0, 0, 0,  0, 1, 1, 0, 0};
    tbl[1]  = '{1, 5, 0, 9, 0,  0, 0, 0, 0,  1, 1, 1, 0, 0};
    tbl[2]  = '{1, 5, 0, 9, 0,  0, 0, 1, 5,  1, 1, 0, 1, 5};
    tbl[3]  = '{1, 5, 0, 9, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 3, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 1, 1,  0, 0, 0, 0,  0, 1, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 2, 1,  0, 0, 0, 0,  0, 1, 2, 0, 0};
    tbl[8]  = '{1, 0, 0, 3, 1,  0, 0, 0, 0,  0, 1, 3, 0, 0};
    tbl[9]  = '{1, 0, 0, 4, 1,  0, 0, 0, 0,  0, 1, 4, 0, 0};
    tbl[10] = '{1, 0, 0, 6, 1,  0, 0, 0, 0,  1, 1, 4, 0, 0};
    tbl[11] = '{1, 0, 0, 6, 1,  0, 0, 1, 2,  1, 1, 3, 1, 2};
    tbl[12] = '{1, 0, 0, 6, 1,  0, 0, 0, 0,  0, 1, 4, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0,  1, 7, 1, 8,  0, 0, 4, 1, 7};
    tbl[14] = '{0, 0, 0, 0, 0,  0, 0, 1, 8,  0, 1, 4, 1, 8};
    tbl[15] = '{0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 4, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 0,  0, 0, 1, 1,  0, 1, 3, 1, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("reset wen",     32'(rf_write_enable), 32'd0);
    chk("reset wreg",    32'(rf_write_reg),    32'd0);
    chk("reset wdata",   rf_write_data,        32'd0);
    chk("reset hold",    32'(alu_hold),        32'd0);
    chk("reset stall",   32'(issue_stall),     32'd0);
    chk("reset ready",   32'(ld_wb_ready),     32'd1);
    chk("reset pending", dut.pending,          32'd0);
    chk("reset count",   32'(dut.count),       32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors: hazard stall, full stall, arbitration, x0 handling.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].lng,
            tbl[i].av, tbl[i].ard, tbl[i].lv, tbl[i].lrd);
      #3;
      chk($sformatf("row%0d tbl stall", i), 32'(issue_stall), 32'(tbl[i].s));
      chk($sformatf("row%0d tbl ready", i), 32'(ld_wb_ready), 32'(tbl[i].r));
      do_cycle($sformatf("row%0d", i));
      chk($sformatf("row%0d tbl count", i), 32'(dut.count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d tbl wen", i), 32'(rf_write_enable), 32'(tbl[i].wen));
      if (tbl[i].wen) chk($sformatf("row%0d tbl wreg", i), 32'(rf_write_reg), 32'(tbl[i].wreg));
    end

    // Reset with three writes outstanding clears everything immediately.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset count",   32'(dut.count),       32'd0);
    chk("midreset pending", dut.pending,          32'd0);
    chk("midreset wen",     32'(rf_write_enable), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 4, 0, 3, 1, 0, 0, 0, 0);
    #3;
    chk("postreset stall", 32'(issue_stall), 32'd0);
    do_cycle("postreset");
    chk("postreset count", 32'(dut.count), 32'd1);

`ifdef WB_STARVE_GUARD_EN
    // ALU valid every cycle: load wins on the fourth try, hold for that cycle only.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 10, (i < 4), 3);
      #3;
      chk($sformatf("starve%0d ready", i), 32'(ld_wb_ready), 32'(i == 3 || i == 4 ? (i == 3) : 0));
      chk($sformatf("starve%0d hold", i),  32'(alu_hold),    32'(i == 3));
      do_cycle($sformatf("starve%0d", i));
    end
    chk("starve count", 32'(dut.count), 32'd0);
`endif

    // Random traffic on a small register window so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1),
            ($urandom_range(0, 3) < 2), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 7));
      #3;
      do_cycle($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, max long-latency writes in flight (1..15).
REQ-002 Parameter STARVE_LIMIT, default 3, cycles a load write may lose arbitration before it gets priority (only with WB_STARVE_GUARD_EN).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 issue_valid  in  1  decode presents an instruction.
REQ-006 issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register numbers.
REQ-007 issue_long  in  1  instruction writes back through the load/long-latency port.
REQ-008 issue_stall  out  1  decode must hold its instruction.
REQ-009 alu_wb_valid, alu_wb_rd, alu_wb_data  in  1/5/32  ALU writeback; no backpressure unless alu_hold.
REQ-010 alu_hold  out  1  ALU pipe must freeze (starve guard only; else tied 0).
REQ-011 ld_wb_valid, ld_wb_rd, ld_wb_data  in  1/5/32  load writeback request.
REQ-012 ld_wb_ready  out  1  load write accepted this cycle when high with ld_wb_valid.
REQ-013 rf_write_enable, rf_write_reg, rf_write_data  out  1/5/32  registered drive of the register-file write port.

Function
REQ-014 Shall keep a 32-bit pending vector; bit r set means a long write to xr is outstanding; bit 0 shall never be set.
REQ-015 Shall keep an outstanding counter (0..MAX_OUTSTANDING) equal to the popcount of the pending vector.
REQ-016 issue_stall = issue_valid and (pending[rs1] or pending[rs2] or pending[rd] or (issue_long and count == MAX_OUTSTANDING)).
REQ-017 On issue_valid, issue_long, !issue_stall, rd != 0: set pending[rd], count +1 next cycle.
REQ-018 On ld_wb_valid and ld_wb_ready: clear pending[ld_wb_rd], count -1; same-cycle set and clear shall net count unchanged.
REQ-019 A stall decision shall use pending state before this cycle's clear; a register cleared in cycle N is issuable in cycle N+1.
REQ-020 Arbitration default: ALU wins; ld_wb_ready = !alu_wb_valid.
REQ-021 Winner registered to rf_write_* one cycle after acceptance; rf_write_enable = 0 when no winner or winner rd == 0.
REQ-022 Cycle N+1 reads of a register accepted in cycle N shall be correct via the register-file write bypass; no extra stall.
REQ-023 Load write to a register not pending shall still be written; pending and count unchanged.

Reset
REQ-024 While rst_n low: pending = 0, count = 0, starve counter = 0, rf_write_enable = 0, rf_write_reg = 0, rf_write_data = 0, alu_hold = 0.
REQ-025 Reset mid-operation discards all outstanding writes; first posedge after release behaves as empty.

Configuration
REQ-026 Macro WB_STARVE_GUARD_EN defined: a counter increments each cycle ld_wb_valid and !ld_wb_ready, clears on acceptance; when it equals STARVE_LIMIT the load wins, ld_wb_ready = 1 and alu_hold = 1 for that cycle.
REQ-027 Macro undefined: no starve counter, alu_hold constant 0, fixed ALU priority.

Structure
REQ-028 Shared package holds REG_ADDR_W = 5, XLEN = 32, NUM_REGS = 32 and the wb request struct {valid, rd, data}.
REQ-029 One sub-module, wb_arb2, holds the two-way priority/starve arbiter; scoreboard logic stays in the top.

Verification
REQ-030 Issue long rd=5; next cycle issue rs1=5 -> issue_stall=1 until ld write rd=5 accepted; issue proceeds the following cycle.
REQ-031 Issue 4 long writes rd=1..4, then long rd=6 -> stalled; accept rd=2 -> rd=6 issues next cycle, count = 4.
REQ-032 alu_wb_valid and ld_wb_valid same cycle, rd=7/rd=8 -> rf_write_reg=7 next cycle, ld_wb_ready=0.
REQ-033 Guard enabled, STARVE_LIMIT=3, ALU valid every cycle with load pending -> load accepted on 4th cycle, alu_hold=1 that cycle only.
REQ-034 Long rd=0 issued -> pending stays 0, count stays 0, no stall on rs=0.
REQ-035 rst_n low with 3 outstanding -> count=0, pending=0, rf_write_enable=0 immediately, no stall after release.
